// File: rtl/pmem_prefetch_arbiter_pkg.sv
// Shared types and address helpers for the physical-memory prefetch arbiter.
package pmem_arb_pkg;

    localparam int ADDR_W      = 32;
    localparam int LINE_W      = 256;
    localparam int OFFSET_W    = 5;
    localparam int PAGE_W      = 12;
    localparam int PF_DISTANCE = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_PF_FETCH = 2'd2
    } arb_state_t;

    // Clear the byte-offset bits so the result names a whole cacheline.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr,
                                                    input int offset_w);
        return addr & ~((ADDR_W'(1) << offset_w) - ADDR_W'(1));
    endfunction

    // True when the two addresses sit in different 2^page_w pages.
    function automatic logic crosses_page(input logic [ADDR_W-1:0] a,
                                          input logic [ADDR_W-1:0] b,
                                          input int page_w);
        return ((a ^ b) >> page_w) != '0;
    endfunction

endpackage

// File: rtl/pmem_prefetch_arbiter_pf_line_buffer.sv
// One-line prefetch buffer. A single address register holds the prefetch
// target while pending and the buffered line address once valid; the two
// flags are never set together, so one register and one comparator suffice.
module pf_line_buffer
    import pmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int LW = 256,
    parameter int OW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_i,
    input  logic [AW-1:0] sched_addr_i,
    input  logic          fill_i,
    input  logic [LW-1:0] fill_data_i,
    input  logic          clear_pending_i,
    input  logic          clear_valid_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          pending_o,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [LW-1:0] data_o,
    output logic          match_o
);

    logic          pending_q, pending_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] data_q, data_d;

    // Next-state for the flags, address and data registers.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (sched_i) begin
            pending_d = 1'b1;
            addr_d    = sched_addr_i;
        end
        if (fill_i) begin
            pending_d = 1'b0;
            valid_d   = 1'b1;
            data_d    = fill_data_i;
        end
        if (clear_pending_i) pending_d = 1'b0;
        if (clear_valid_i)   valid_d   = 1'b0;
    end

    // Buffer state registers; reset abandons any scheduled or held line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign pending_o = pending_q;
    assign valid_o   = valid_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign match_o   = (line_addr(lookup_addr_i, OW) == addr_q);

endmodule

// File: rtl/pmem_prefetch_arbiter.sv
// Physical-memory port owner: forwards demand traffic, runs next-line
// prefetches into a one-line buffer and serves buffer hits without the adapter.
module pmem_prefetch_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int OFFSET_W    = 5,
    parameter int PAGE_W      = 12,
    parameter int PF_DISTANCE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_pmem_read,
    input  logic              cache_pmem_write,
    input  logic [ADDR_W-1:0] cache_pmem_addr,
    input  logic [LINE_W-1:0] cache_pmem_wdata,
    output logic              cache_pmem_resp,
    output logic [LINE_W-1:0] cache_pmem_rdata,
    input  logic              prefetch_start,
    output logic              prefetch_ready,
    input  logic              pf_consume,
    output logic [ADDR_W-1:0] pf_addr,
    output logic [LINE_W-1:0] pf_data,
    output logic              adapter_read,
    output logic              adapter_write,
    output logic [ADDR_W-1:0] adapter_addr,
    output logic [LINE_W-1:0] adapter_wdata,
    input  logic              adapter_resp,
    input  logic [LINE_W-1:0] adapter_rdata
);

    arb_state_t        state_q, state_d;
    logic              hit_q, hit_d;

    logic              buf_pending, buf_valid, buf_match;
    logic [ADDR_W-1:0] buf_addr;
    logic [LINE_W-1:0] buf_data;
    logic              sched, fill, clr_pending, clr_valid;
    logic [ADDR_W-1:0] pf_target;
    logic              pf_crosses;

    assign pf_target  = line_addr(cache_pmem_addr, OFFSET_W) + (ADDR_W'(PF_DISTANCE) << OFFSET_W);
    assign pf_crosses = crosses_page(pf_target, cache_pmem_addr, PAGE_W);

    pf_line_buffer #(
        .AW (ADDR_W),
        .LW (LINE_W),
        .OW (OFFSET_W)
    ) u_buf (
        .clk             (clk),
        .rst             (rst),
        .sched_i         (sched),
        .sched_addr_i    (pf_target),
        .fill_i          (fill),
        .fill_data_i     (adapter_rdata),
        .clear_pending_i (clr_pending),
        .clear_valid_i   (clr_valid),
        .lookup_addr_i   (cache_pmem_addr),
        .pending_o       (buf_pending),
        .valid_o         (buf_valid),
        .addr_o          (buf_addr),
        .data_o          (buf_data),
        .match_o         (buf_match)
    );

    // Arbitration FSM, hazard resolution at grant, and port muxing.
    always_comb begin
        state_d          = state_q;
        hit_d            = 1'b0;
        sched            = 1'b0;
        fill             = 1'b0;
        clr_pending      = 1'b0;
        clr_valid        = pf_consume;
        cache_pmem_resp  = 1'b0;
        cache_pmem_rdata = '0;
        adapter_read     = 1'b0;
        adapter_write    = 1'b0;
        adapter_addr     = '0;
        adapter_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (hit_q) begin
                    // Buffer hit answered from the held line; the request
                    // is still up this cycle and must not be re-granted.
                    cache_pmem_resp  = 1'b1;
                    cache_pmem_rdata = buf_data;
                end else if (cache_pmem_write) begin
                    // A writeback makes any prefetched copy of that line stale.
                    if (buf_match && (buf_pending || buf_valid)) begin
                        clr_pending = 1'b1;
                        clr_valid   = 1'b1;
                    end
                    state_d = ST_DEMAND;
                end else if (cache_pmem_read) begin
                    if (buf_match && buf_pending) begin
                        clr_pending = 1'b1;
                        state_d     = ST_DEMAND;
                    end else if (buf_match && buf_valid && !pf_consume) begin
                        clr_valid = 1'b1;
                        hit_d     = 1'b1;
                    end else begin
                        state_d = ST_DEMAND;
                    end
                end else if (buf_pending) begin
                    state_d = ST_PF_FETCH;
                end
            end
            ST_DEMAND: begin
                adapter_read     = cache_pmem_read;
                adapter_write    = cache_pmem_write;
                adapter_addr     = cache_pmem_addr;
                adapter_wdata    = cache_pmem_wdata;
                cache_pmem_resp  = adapter_resp;
                cache_pmem_rdata = adapter_rdata;
                if (cache_pmem_read && prefetch_start && !buf_pending && !buf_valid && !pf_crosses)
                    sched = 1'b1;
                if (adapter_resp) state_d = ST_IDLE;
            end
            ST_PF_FETCH: begin
                adapter_read = 1'b1;
                adapter_addr = buf_addr;
                if (adapter_resp) begin
                    fill    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and the one-cycle buffer-hit response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    assign prefetch_ready = buf_valid;
    assign pf_addr        = buf_addr;
    assign pf_data        = buf_data;

endmodule

// File: tb/tb_pmem_prefetch_arbiter.sv
// Scoreboard bench for pmem_prefetch_arbiter: directed cache traffic, a
// fixed-latency adapter model, and a monitor checking responses, adapter
// requests and buffer fills against queued expectations.
module tb_pmem_prefetch_arbiter;

    logic         clk;
    logic         rst;
    logic         cache_pmem_read, cache_pmem_write;
    logic [31:0]  cache_pmem_addr;
    logic [255:0] cache_pmem_wdata;
    logic         cache_pmem_resp;
    logic [255:0] cache_pmem_rdata;
    logic         prefetch_start, prefetch_ready, pf_consume;
    logic [31:0]  pf_addr;
    logic [255:0] pf_data;
    logic         adapter_read, adapter_write;
    logic [31:0]  adapter_addr;
    logic [255:0] adapter_wdata;
    logic         adapter_resp;
    logic [255:0] adapter_rdata;

    typedef struct { logic is_read; logic [255:0] data; logic need_ready; } rsp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [255:0] wdata; } adp_t;
    typedef struct { logic [31:0] addr; logic [255:0] data; } pf_t;

    rsp_t q_rsp[$];
    adp_t q_adp[$];
    pf_t  q_pf[$];

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    localparam int ADP_LAT = 4;
    localparam logic [255:0] WD1 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] WD2 = {8{32'h1234_5678}};

    pmem_prefetch_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .cache_pmem_read  (cache_pmem_read),
        .cache_pmem_write (cache_pmem_write),
        .cache_pmem_addr  (cache_pmem_addr),
        .cache_pmem_wdata (cache_pmem_wdata),
        .cache_pmem_resp  (cache_pmem_resp),
        .cache_pmem_rdata (cache_pmem_rdata),
        .prefetch_start   (prefetch_start),
        .prefetch_ready   (prefetch_ready),
        .pf_consume       (pf_consume),
        .pf_addr          (pf_addr),
        .pf_data          (pf_data),
        .adapter_read     (adapter_read),
        .adapter_write    (adapter_write),
        .adapter_addr     (adapter_addr),
        .adapter_wdata    (adapter_wdata),
        .adapter_resp     (adapter_resp),
        .adapter_rdata    (adapter_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen through the adapter: a fixed function of the line address.
    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic exp_adp(input logic wr, input logic [31:0] a, input logic [255:0] wd);
        adp_t e;
        e.wr = wr; e.addr = a; e.wdata = wd;
        q_adp.push_back(e);
    endtask

    task automatic exp_rsp(input logic rd, input logic [255:0] d, input logic need);
        rsp_t e;
        e.is_read = rd; e.data = d; e.need_ready = need;
        q_rsp.push_back(e);
    endtask

    task automatic exp_pf(input logic [31:0] a);
        pf_t e;
        e.addr = a; e.data = mem_line(a);
        q_pf.push_back(e);
    endtask

    // Adapter model: responds after ADP_LAT cycles of a held request.
    initial begin
        int cnt;
        cnt = 0;
        adapter_resp  = 1'b0;
        adapter_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                adapter_resp = 1'b0;
            end else if (adapter_resp) begin
                adapter_resp = 1'b0;
                cnt = 0;
            end else if (adapter_read || adapter_write) begin
                cnt++;
                if (cnt == ADP_LAT) begin
                    adapter_resp  = 1'b1;
                    adapter_rdata = mem_line(adapter_addr);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response,
    // starts an adapter transaction, or raises prefetch_ready.
    initial begin
        logic prev_act, prev_rdy;
        rsp_t r;
        adp_t a;
        pf_t  p;
        prev_act = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_act = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (cache_pmem_resp) begin
                    if (q_rsp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_resp: got resp=1 want none");
                    end else begin
                        r = q_rsp.pop_front();
                        if (r.is_read) check("resp_rdata", cache_pmem_rdata, r.data);
                        if (r.need_ready) check("resp_after_pf_fill", 256'(prefetch_ready), 256'(1));
                    end
                end
                if ((adapter_read || adapter_write) && !prev_act) begin
                    if (q_adp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_adapter: got wr=%0b addr=%h want none", adapter_write, adapter_addr);
                    end else begin
                        a = q_adp.pop_front();
                        check("adapter_wr", 256'(adapter_write), 256'(a.wr));
                        check("adapter_addr", 256'(adapter_addr), 256'(a.addr));
                        if (a.wr) check("adapter_wdata", adapter_wdata, a.wdata);
                    end
                end
                if (prefetch_ready && !prev_rdy) begin
                    if (q_pf.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_pf_fill: got addr=%h want none", pf_addr);
                    end else begin
                        p = q_pf.pop_front();
                        check("pf_addr", 256'(pf_addr), 256'(p.addr));
                        check("pf_data", pf_data, p.data);
                    end
                end
                prev_act = adapter_read || adapter_write;
                prev_rdy = prefetch_ready;
            end
        end
    end

    // Issue one demand request at posedge+1 and hold it until the response.
    task automatic demand(input logic wr, input logic [31:0] a, input logic [255:0] wd,
                          input logic pfs, output int cycles);
        cache_pmem_read  = !wr;
        cache_pmem_write = wr;
        cache_pmem_addr  = a;
        cache_pmem_wdata = wd;
        prefetch_start   = pfs;
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (cache_pmem_resp) break;
            if (cycles > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL demand_timeout: got no resp for %h want resp", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        cache_pmem_read  = 1'b0;
        cache_pmem_write = 1'b0;
        prefetch_start   = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!prefetch_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!prefetch_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got prefetch_ready=0 want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        pf_consume = 1'b1;
        @(posedge clk);
        #1;
        pf_consume = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        cache_pmem_read  = 1'b0;
        cache_pmem_write = 1'b0;
        cache_pmem_addr  = '0;
        cache_pmem_wdata = '0;
        prefetch_start   = 1'b0;
        pf_consume       = 1'b0;
        #2;
        check("rst_adapter_req", 256'({adapter_read, adapter_write}), 256'(0));
        check("rst_cache_resp", 256'(cache_pmem_resp), 256'(0));
        check("rst_prefetch_ready", 256'(prefetch_ready), 256'(0));
        check("rst_pf_addr", 256'(pf_addr), 256'(0));
        check("rst_pf_data", pf_data, 256'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Miss with prefetch: next line fetched into the buffer, then consumed.
        exp_adp(1'b0, 32'h0000_1040, '0);
        exp_rsp(1'b1, mem_line(32'h0000_1040), 1'b0);
        exp_adp(1'b0, 32'h0000_1060, '0);
        exp_pf(32'h0000_1060);
        demand(1'b0, 32'h0000_1040, '0, 1'b1, lat);
        check("t1_demand_latency", 256'(lat), 256'(5));
        wait_ready();
        consume();
        check("t1_ready_after_consume", 256'(prefetch_ready), 256'(0));

        // Last line of a page: the prefetch is dropped.
        exp_adp(1'b0, 32'h0000_1FE0, '0);
        exp_rsp(1'b1, mem_line(32'h0000_1FE0), 1'b0);
        demand(1'b0, 32'h0000_1FE0, '0, 1'b1, lat);
        check("t2_demand_latency", 256'(lat), 256'(5));
        idle(10);
        check("t2_no_prefetch", 256'(prefetch_ready), 256'(0));
        check("t2_adapter_idle", 256'({adapter_read, adapter_write}), 256'(0));

        // Writeback arriving during a prefetch burst waits for it.
        exp_adp(1'b0, 32'h0000_3000, '0);
        exp_rsp(1'b1, mem_line(32'h0000_3000), 1'b0);
        exp_adp(1'b0, 32'h0000_3020, '0);
        exp_pf(32'h0000_3020);
        demand(1'b0, 32'h0000_3000, '0, 1'b1, lat);
        idle(1);
        check("t3_pf_fetch_active", 256'(adapter_read), 256'(1));
        exp_adp(1'b1, 32'h0000_2000, WD1);
        exp_rsp(1'b0, '0, 1'b1);
        demand(1'b1, 32'h0000_2000, WD1, 1'b0, lat);
        check("t3_wb_latency", 256'(lat), 256'(9));

        // Demand read hitting the buffer: no adapter access, 1-cycle response.
        exp_rsp(1'b1, mem_line(32'h0000_3020), 1'b0);
        demand(1'b0, 32'h0000_3020, '0, 1'b0, lat);
        check("t4_hit_latency", 256'(lat), 256'(2));
        check("t4_ready_dropped", 256'(prefetch_ready), 256'(0));
        idle(3);

        // Demand write to the buffered line invalidates it and goes to the adapter.
        exp_adp(1'b0, 32'h0000_3000, '0);
        exp_rsp(1'b1, mem_line(32'h0000_3000), 1'b0);
        exp_adp(1'b0, 32'h0000_3020, '0);
        exp_pf(32'h0000_3020);
        demand(1'b0, 32'h0000_3000, '0, 1'b1, lat);
        wait_ready();
        exp_adp(1'b1, 32'h0000_3020, WD2);
        exp_rsp(1'b0, '0, 1'b0);
        demand(1'b1, 32'h0000_3020, WD2, 1'b0, lat);
        check("t5_write_latency", 256'(lat), 256'(5));
        check("t5_ready_invalidated", 256'(prefetch_ready), 256'(0));

        // Consume in the same cycle as a buffer-hit grant: demand uses the adapter.
        exp_adp(1'b0, 32'h0000_5000, '0);
        exp_rsp(1'b1, mem_line(32'h0000_5000), 1'b0);
        exp_adp(1'b0, 32'h0000_5020, '0);
        exp_pf(32'h0000_5020);
        demand(1'b0, 32'h0000_5000, '0, 1'b1, lat);
        wait_ready();
        pf_consume = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                pf_consume = 1'b0;
            end
        join_none
        exp_adp(1'b0, 32'h0000_5020, '0);
        exp_rsp(1'b1, mem_line(32'h0000_5020), 1'b0);
        demand(1'b0, 32'h0000_5020, '0, 1'b0, lat);
        check("t5b_race_latency", 256'(lat), 256'(5));
        check("t5b_ready_cleared", 256'(prefetch_ready), 256'(0));

        // Demand read of the pending target cancels the prefetch.
        exp_adp(1'b0, 32'h0000_6000, '0);
        exp_rsp(1'b1, mem_line(32'h0000_6000), 1'b0);
        exp_adp(1'b0, 32'h0000_6020, '0);
        exp_rsp(1'b1, mem_line(32'h0000_6020), 1'b0);
        demand(1'b0, 32'h0000_6000, '0, 1'b1, lat);
        demand(1'b0, 32'h0000_6020, '0, 1'b0, lat);
        check("t5c_cancel_latency", 256'(lat), 256'(5));
        idle(10);
        check("t5c_no_fill", 256'(prefetch_ready), 256'(0));
        check("t5c_adapter_idle", 256'({adapter_read, adapter_write}), 256'(0));

        // Asynchronous reset in the middle of a prefetch burst.
        exp_adp(1'b0, 32'h0000_0040, '0);
        exp_rsp(1'b1, mem_line(32'h0000_0040), 1'b0);
        exp_adp(1'b0, 32'h0000_0060, '0);
        demand(1'b0, 32'h0000_0040, '0, 1'b1, lat);
        idle(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_adapter_read", 256'(adapter_read), 256'(0));
        check("t6_rst_ready", 256'(prefetch_ready), 256'(0));
        check("t6_rst_pf_addr", 256'(pf_addr), 256'(0));
        check("t6_rst_resp", 256'(cache_pmem_resp), 256'(0));
        idle(2);
        rst = 1'b0;
        idle(1);
        exp_adp(1'b0, 32'h0000_0040, '0);
        exp_rsp(1'b1, mem_line(32'h0000_0040), 1'b0);
        exp_adp(1'b0, 32'h0000_0060, '0);
        exp_pf(32'h0000_0060);
        demand(1'b0, 32'h0000_0040, '0, 1'b1, lat);
        check("t6_demand_latency", 256'(lat), 256'(5));
        wait_ready();
        consume();
        check("t6_ready_after_consume", 256'(prefetch_ready), 256'(0));

        idle(10);
        check("left_resp_queue", 256'(q_rsp.size()), 256'(0));
        check("left_adapter_queue", 256'(q_adp.size()), 256'(0));
        check("left_pf_queue", 256'(q_pf.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
